crc_frame_checker: RTL and testbench

Receive-side companion to the team's byte-wide CRC-CCITT generator and parity logic. It accepts a byte stream with start/end-of-frame markers and a per-byte parity bit, and runs CRC-16-CCITT over the payload plus the appended CRC bytes. At frame end it reports pass/fail, error cause and payload length. It sits between the byte deframer and the packet buffer, which uses `frame_ok` to commit or discard the frame.

---
 rtl/crc_frame_checker_if.sv | 33 +++
 rtl/crc_frame_checker.sv | 157 +++++++++++++++
 tb/tb_crc_frame_checker.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_frame_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | crc_frame_checker_if                                                       |
// | Byte stream in, frame status out, for the receive-side CRC frame checker.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface crc_frame_checker_if;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        parity_in;
    logic        sof;
    logic        eof;
    logic        frame_done;
    logic        frame_ok;
    logic        crc_error;
    logic        parity_error;
    logic        length_error;
    logic        frame_abort;
    logic [15:0] payload_len;

    modport master (
        output data_in, data_valid, parity_in, sof, eof,
        input  frame_done, frame_ok, crc_error, parity_error, length_error,
               frame_abort, payload_len
    );

    modport slave (
        input  data_in, data_valid, parity_in, sof, eof,
        output frame_done, frame_ok, crc_error, parity_error, length_error,
               frame_abort, payload_len
    );
endinterface
`default_nettype wire

// File: rtl/crc_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | crc_frame_checker                                                          |
// | CRC-16/CCITT-FALSE, parity and length check of framed bytes; one report   |
// | per frame for the packet buffer.  Revision: 1.0                            |
// +----------------------------------------------------------------------------+
module crc_frame_checker #(
    parameter int MAX_LEN = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    crc_frame_checker_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DROP = 2'd2
    } state_t;

    localparam logic [16:0] c_MAX_LEN  = 17'(MAX_LEN);
    localparam logic [16:0] c_CNT_SAT  = 17'(MAX_LEN + 1);
    localparam logic [15:0] c_CRC_INIT = 16'hFFFF;

    function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] crc_q, crc_d;
    logic [16:0] cnt_q, cnt_d;
    logic        par_q, par_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;
    logic        ok_q, ok_d;
    logic        crc_err_q, crc_err_d;
    logic        par_err_q, par_err_d;
    logic        len_err_q, len_err_d;
    logic [15:0] plen_q, plen_d;

    logic        w_par_mm;
    logic [16:0] w_cnt_inc;
    logic        w_rep;
    logic [16:0] w_rep_cnt;
    logic [15:0] w_rep_res;
    logic        w_rep_par;
    logic        w_len_err;
    logic        w_crc_err;

    always_comb begin
        w_par_mm  = (^bus.data_in) ^ bus.parity_in;
        w_cnt_inc = (cnt_q >= c_CNT_SAT) ? c_CNT_SAT : cnt_q + 17'd1;

        state_d   = state_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        par_d     = par_q;
        abort_d   = 1'b0;
        w_rep     = 1'b0;
        w_rep_cnt = cnt_q;
        w_rep_res = crc_q;
        w_rep_par = par_q;

        if (bus.data_valid) begin
            if (bus.sof) begin
                // A sof always restarts the frame; outside IDLE it also cuts one off.
                abort_d = (state_q != S_IDLE);
                crc_d   = crc_byte(c_CRC_INIT, bus.data_in);
                cnt_d   = 17'd1;
                par_d   = w_par_mm;
                if (bus.eof) begin
                    w_rep     = 1'b1;
                    w_rep_cnt = 17'd1;
                    w_rep_res = crc_d;
                    w_rep_par = w_par_mm;
                    state_d   = S_IDLE;
                end else begin
                    state_d   = S_RECV;
                end
            end else if (state_q != S_IDLE) begin
                crc_d = crc_byte(crc_q, bus.data_in);
                cnt_d = w_cnt_inc;
                par_d = par_q | w_par_mm;
                if (bus.eof) begin
                    w_rep     = 1'b1;
                    w_rep_cnt = w_cnt_inc;
                    w_rep_res = crc_d;
                    w_rep_par = par_d;
                    state_d   = S_IDLE;
                end else if ((state_q == S_RECV) && (w_cnt_inc > c_MAX_LEN)) begin
                    state_d   = S_DROP;
                end
            end
        end

        w_len_err = (w_rep_cnt < 17'd3) || (w_rep_cnt > c_MAX_LEN);
        w_crc_err = (w_rep_res != 16'h0000) && !w_len_err;

        // Status holds between reports; only a report cycle reloads it.
        done_d    = w_rep;
        ok_d      = ok_q;
        crc_err_d = crc_err_q;
        par_err_d = par_err_q;
        len_err_d = len_err_q;
        plen_d    = plen_q;
        if (w_rep) begin
            len_err_d = w_len_err;
            crc_err_d = w_crc_err;
            par_err_d = w_rep_par;
            ok_d      = !(w_len_err || w_crc_err || w_rep_par);
            plen_d    = w_len_err ? 16'd0 : 16'(w_rep_cnt - 17'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            crc_q     <= c_CRC_INIT;
            cnt_q     <= 17'd0;
            par_q     <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            ok_q      <= 1'b0;
            crc_err_q <= 1'b0;
            par_err_q <= 1'b0;
            len_err_q <= 1'b0;
            plen_q    <= 16'd0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            par_q     <= par_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            ok_q      <= ok_d;
            crc_err_q <= crc_err_d;
            par_err_q <= par_err_d;
            len_err_q <= len_err_d;
            plen_q    <= plen_d;
        end
    end

    assign bus.frame_done   = done_q;
    assign bus.frame_abort  = abort_q;
    assign bus.frame_ok     = ok_q;
    assign bus.crc_error    = crc_err_q;
    assign bus.parity_error = par_err_q;
    assign bus.length_error = len_err_q;
    assign bus.payload_len  = plen_q;

endmodule
`default_nettype wire

// File: tb/tb_crc_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_crc_frame_checker                                                       |
// | Two checkers (MAX_LEN 256 and 8) on one stream against a frame-level model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_crc_frame_checker;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    crc_frame_checker_if if0 ();
    crc_frame_checker_if if8 ();

    crc_frame_checker #(.MAX_LEN(256)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    crc_frame_checker #(.MAX_LEN(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8.slave)
    );

    typedef struct {
        int due;
        bit ok;
        bit ce;
        bit pe;
        bit le;
        int pl;
    } rep_t;

    int         n_chk   = 0;
    int         n_fail  = 0;
    int         ncyc    = 0;
    int         rst_due = -1;
    bit         mon_en  = 1'b0;
    bit         open_f  = 1'b0;
    bit         par_acc = 1'b0;
    logic [7:0] frm[$];
    logic [7:0] asc[$];
    rep_t       dq0[$];
    rep_t       dq1[$];
    int         aq[$];
    rep_t       held0 = '{default: 0};
    rep_t       held1 = '{default: 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Plain long-hand CRC-16/CCITT-FALSE over a whole byte list.
    function automatic logic [15:0] crc_of(input logic [7:0] q[$]);
        int c;
        c = 'hFFFF;
        foreach (q[i]) begin
            c = c ^ (int'(q[i]) << 8);
            for (int b = 0; b < 8; b++) begin
                c = c << 1;
                if ((c & 'h10000) != 0) c = c ^ 'h11021;
            end
        end
        return 16'(c);
    endfunction

    function automatic rep_t make_rep(input int maxl, input int due);
        rep_t r;
        int   n;
        n    = frm.size();
        r.due = due;
        r.le  = (n < 3) || (n > maxl);
        r.pe  = par_acc;
        r.ce  = !r.le && (crc_of(frm) != 16'h0000);
        r.ok  = !(r.le || r.ce || r.pe);
        r.pl  = r.le ? 0 : n - 2;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [7:0] d, input logic s, input logic e,
                         input logic p, input logic rst);
        @(posedge clk);
        #1;
        reset          = rst;
        if0.data_valid = v;  if8.data_valid = v;
        if0.data_in    = d;  if8.data_in    = d;
        if0.sof        = s;  if8.sof        = s;
        if0.eof        = e;  if8.eof        = e;
        if0.parity_in  = p;  if8.parity_in  = p;
    endtask

    // Junk on the qualified inputs while data_valid is low must be ignored.
    task automatic idle_cycle();
        drive(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic send(input logic [7:0] d, input bit s, input bit e, input bit bad, input int gap);
        repeat ($urandom_range(gap, 0)) idle_cycle();
        drive(1'b1, d, s, e, (^d) ^ bad, 1'b0);
        if (s) begin
            if (open_f) aq.push_back(ncyc + 1);
            frm.delete();
            frm.push_back(d);
            par_acc = bad;
            open_f  = 1'b1;
        end else if (open_f) begin
            frm.push_back(d);
            par_acc = par_acc | bad;
        end
        if (e && open_f) begin
            dq0.push_back(make_rep(256, ncyc + 1));
            dq1.push_back(make_rep(8, ncyc + 1));
            open_f = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b[$], input int bad_idx, input int gap);
        for (int i = 0; i < b.size(); i++)
            send(b[i], i == 0, i == b.size() - 1, i == bad_idx, gap);
    endtask

    task automatic send_good(input int plen, input bit bad_crc, input int bad_idx, input int gap);
        logic [7:0]  b[$];
        logic [15:0] c;
        for (int i = 0; i < plen; i++) b.push_back(8'($urandom));
        c = crc_of(b);
        if (bad_crc) c = c ^ 16'(1 << $urandom_range(15, 0));
        b.push_back(c[15:8]);
        b.push_back(c[7:0]);
        send_frame(b, bad_idx, gap);
    endtask

    task automatic do_reset();
        idle_cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_due = ncyc + 1;
        open_f  = 1'b0;
        frm.delete();
        aq.delete();
        dq0.delete();
        dq1.delete();
    endtask

    task automatic mon(input int k, input logic d, input logic ab, input logic ok, input logic ce,
                       input logic pe, input logic le, input logic [15:0] pl, input bit exp_ab);
        bit    ed;
        rep_t  h;
        string p;
        ed = 1'b0;
        p  = (k == 0) ? "L256" : "L8";
        if (k == 0) begin
            if (dq0.size() > 0 && dq0[0].due == ncyc) begin held0 = dq0.pop_front(); ed = 1'b1; end
            h = held0;
        end else begin
            if (dq1.size() > 0 && dq1[0].due == ncyc) begin held1 = dq1.pop_front(); ed = 1'b1; end
            h = held1;
        end
        chk({p, ".frame_done"},   d,  ed);
        chk({p, ".frame_abort"},  ab, exp_ab);
        chk({p, ".frame_ok"},     ok, h.ok);
        chk({p, ".crc_error"},    ce, h.ce);
        chk({p, ".parity_error"}, pe, h.pe);
        chk({p, ".length_error"}, le, h.le);
        chk({p, ".payload_len"},  pl, h.pl);
    endtask

    always @(negedge clk) begin
        bit exp_ab;
        if (mon_en) begin
            if (ncyc == rst_due) begin
                held0 = '{default: 0};
                held1 = '{default: 0};
            end
            exp_ab = (aq.size() > 0) && (aq[0] == ncyc);
            if (exp_ab) void'(aq.pop_front());
            mon(0, if0.frame_done, if0.frame_abort, if0.frame_ok, if0.crc_error,
                if0.parity_error, if0.length_error, if0.payload_len, exp_ab);
            mon(1, if8.frame_done, if8.frame_abort, if8.frame_ok, if8.crc_error,
                if8.parity_error, if8.length_error, if8.payload_len, exp_ab);
        end
        ncyc++;
    end

    initial begin
        logic [7:0] bad_last[$];
        asc = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
        reset = 1'b1;
        if0.data_valid = 1'b0;  if8.data_valid = 1'b0;
        if0.data_in    = 8'h00; if8.data_in    = 8'h00;
        if0.sof        = 1'b0;  if8.sof        = 1'b0;
        if0.eof        = 1'b0;  if8.eof        = 1'b0;
        if0.parity_in  = 1'b0;  if8.parity_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (2) idle_cycle();

        send_frame(asc, -1, 0);                       // check string, good CRC
        bad_last = asc;
        bad_last[10] = 8'hB0;
        send_frame(bad_last, -1, 0);                  // corrupted CRC low byte
        send_frame(asc, 2, 3);                        // parity flip on byte 3, gaps
        send_good(8, 1'b0, -1, 0);                    // 10-byte frame
        send_good(0, 1'b0, -1, 1);                    // 2-byte frame
        send(8'h5A, 1'b1, 1'b1, 1'b0, 0);             // single sof&eof byte
        for (int i = 0; i < 4; i++) send(asc[i], i == 0, 1'b0, 1'b0, 0);
        send_frame(asc, -1, 0);                       // sof on byte 5 aborts, then good frame
        for (int i = 0; i < 5; i++) send(asc[i], i == 0, 1'b0, 1'b0, 0);
        do_reset();
        idle_cycle();
        send_frame(asc, -1, 0);                       // good frame after mid-frame reset
        send_good(254, 1'b0, -1, 0);                  // exactly 256 bytes
        send_good(255, 1'b0, -1, 0);                  // 257 bytes
        send_good(7, 1'b0, -1, 0);                    // 9 bytes: just over the small limit

        for (int it = 0; it < 60; it++) begin
            int sel;
            int plen;
            int gap;
            sel = $urandom_range(9, 0);
            gap = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(2, 0));
            if ($urandom_range(5, 0) == 0)
                send(8'($urandom), 1'b0, 1'($urandom), 1'($urandom), gap);
            if ($urandom_range(4, 0) == 0) begin
                int n;
                n = $urandom_range(12, 1);
                for (int j = 0; j < n; j++) send(8'($urandom), j == 0, 1'b0, 1'b0, gap);
            end
            if (sel == 9) begin
                send(8'($urandom), 1'b1, 1'b1, 1'($urandom), gap);
            end else begin
                if (sel == 0)      plen = $urandom_range(256, 250);
                else if (sel <= 3) plen = $urandom_range(8, 4);
                else               plen = $urandom_range(20, 0);
                send_good(plen, $urandom_range(3, 0) == 0,
                          ($urandom_range(9, 0) == 0) ? int'($urandom_range(plen + 1, 0)) : -1, gap);
            end
        end

        repeat (5) idle_cycle();
        chk("pending_reports", dq0.size() + dq1.size(), 0);
        chk("pending_aborts", aq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
